// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: a direct-mapped BTB with a 2-bit saturating
// direction counter per entry, trained by resolved-branch feedback.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] fetch_pc,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_pc,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [DATA_W-1:0] upd_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = DATA_W - IDX_W - 2;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [DATA_W-1:0] target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [1:0]       u_ctr;
  logic             upd_pc_unused;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[DATA_W-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[DATA_W-1:IDX_W+2];
  assign upd_pc_unused = ^upd_pc[1:0];

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  always_comb begin
    f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken = f_hit && ctr_q[f_idx][1];
    pred_pc    = pred_taken ? target_q[f_idx] : fetch_pc + DATA_W'(4);
  end

  always_comb begin
    u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_ctr = ctr_q[u_idx];
    if (upd_taken) begin
      if (ctr_q[u_idx] != 2'b11) u_ctr = ctr_q[u_idx] + 2'd1;
    end else begin
      if (ctr_q[u_idx] != 2'b00) u_ctr = ctr_q[u_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= u_ctr;
        if (upd_taken) target_q[u_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table of fetch/update steps
// plus hand-written reset sequences, checked through an expected-result queue.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  branch_predictor #(.ENTRIES(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_pc(pred_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        exp_t;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    string       name;
    logic        t;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic fl, logic [31:0] fpc, logic uv, logic [31:0] upc,
                              logic ut, logic [31:0] utgt, logic et, logic [31:0] epc);
    vec_t v;
    v.fl = fl; v.fpc = fpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.exp_t = et; v.exp_pc = epc;
    return v;
  endfunction

  task automatic expect_out(input string name, input logic t, input logic [31:0] pc);
    exp_t e;
    e.name = name; e.t = t; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (pred_taken !== e.t || pred_pc !== e.pc) begin
      n_bad++;
      $display("FAIL %s: got taken=%b pc=%h, want taken=%b pc=%h",
               e.name, pred_taken, pred_pc, e.t, e.pc);
    end
  endtask

  task automatic drive_idle(input logic [31:0] fpc);
    flush = 1'b0; fetch_pc = fpc;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];

    // Steps: inputs applied after negedge, outputs checked before the next posedge.
    vecs.push_back(mk(0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h104)); // 0 reset state
    vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h180, 0, 32'h104)); // 1 alloc, no bypass
    vecs.push_back(mk(0, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h180)); // 2 ctr 10
    vecs.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h180)); // 3 ->01
    vecs.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h104)); // 4 ->00
    vecs.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h104)); // 5 stays 00
    vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h180, 0, 32'h104)); // 6 ->01
    vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h180, 0, 32'h104)); // 7 ->10
    vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h1C0, 1, 32'h180)); // 8 ->11, tgt 1C0
    vecs.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h1C0, 1, 32'h1C0)); // 9 stays 11
    vecs.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h1C0)); // 10 ->10
    vecs.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h1C0)); // 11 ->01
    vecs.push_back(mk(0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h104)); // 12
    vecs.push_back(mk(0, 32'h140, 1, 32'h100, 1, 32'h180, 0, 32'h144)); // 13 alias miss, 100->10
    vecs.push_back(mk(0, 32'h100, 1, 32'h140, 1, 32'h200, 1, 32'h180)); // 14 overwrite idx 0
    vecs.push_back(mk(0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h104)); // 15 evicted
    vecs.push_back(mk(0, 32'h140, 0, 32'h0,   0, 32'h0,   1, 32'h200)); // 16
    vecs.push_back(mk(0, 32'h300, 1, 32'h300, 0, 32'h0,   0, 32'h304)); // 17 NT miss
    vecs.push_back(mk(0, 32'h300, 0, 32'h0,   0, 32'h0,   0, 32'h304)); // 18 still invalid
    vecs.push_back(mk(0, 32'h140, 0, 32'h0,   0, 32'h0,   1, 32'h200)); // 19 occupant intact
    vecs.push_back(mk(0, 32'h208, 1, 32'h208, 1, 32'h400, 0, 32'h20C)); // 20 alloc idx 2
    vecs.push_back(mk(0, 32'h208, 0, 32'h0,   0, 32'h0,   1, 32'h400)); // 21
    vecs.push_back(mk(0, 32'h208, 0, 32'h208, 0, 32'h0,   1, 32'h400)); // 22 upd_valid=0
    vecs.push_back(mk(0, 32'h208, 0, 32'h208, 0, 32'h0,   1, 32'h400)); // 23 unchanged
    vecs.push_back(mk(0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0));  // 24 pc wrap
    vecs.push_back(mk(1, 32'h140, 1, 32'h208, 1, 32'h400, 1, 32'h200)); // 25 flush + update
    vecs.push_back(mk(0, 32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h144)); // 26 flushed
    vecs.push_back(mk(0, 32'h208, 0, 32'h0,   0, 32'h0,   0, 32'h20C)); // 27 update dropped
    vecs.push_back(mk(0, 32'h208, 1, 32'h208, 1, 32'h400, 0, 32'h20C)); // 28 re-alloc
    vecs.push_back(mk(0, 32'h208, 0, 32'h0,   0, 32'h0,   1, 32'h400)); // 29

    rst = 1'b1;
    drive_idle(32'h100);
    #1;
    expect_out("reset_lookup", 1'b0, 32'h104);
    check_out();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      flush = vecs[i].fl; fetch_pc = vecs[i].fpc;
      upd_valid = vecs[i].uv; upd_pc = vecs[i].upc;
      upd_taken = vecs[i].ut; upd_target = vecs[i].utgt;
      #1;
      expect_out($sformatf("vec%0d", i), vecs[i].exp_t, vecs[i].exp_pc);
      check_out();
    end

    // Asynchronous reset pulse strictly between clock edges.
    @(negedge clk);
    drive_idle(32'h208);
    #1;
    expect_out("pre_async_rst", 1'b1, 32'h400);
    check_out();
    rst = 1'b1;
    #1;
    expect_out("async_rst_no_edge", 1'b0, 32'h20C);
    check_out();
    rst = 1'b0;
    #1;
    expect_out("after_async_rst", 1'b0, 32'h20C);
    check_out();
    @(negedge clk);
    #1;
    expect_out("after_async_rst_edge", 1'b0, 32'h20C);
    check_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
